// File: rtl/clock_reset_sequencer_pkg.sv
// Shared types and widths for the clock/reset sequencer: FSM state encoding,
// retry/loss counter widths and the saturating loss-counter increment.
package clk_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PULSE = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_STABLE_WAIT = 3'd2,
        ST_RUN         = 3'd3,
        ST_FAILED      = 3'd4
    } seq_state_e;

    localparam int RETRY_W = 3;
    localparam int LOSS_W  = 8;

    localparam logic [LOSS_W-1:0] LOSS_MAX = 8'hFF;

    function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] value);
        logic [LOSS_W-1:0] result;
        if (value == LOSS_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/clock_reset_sequencer_if.sv
// Status/control bundle between the sequencer (master) and the clock
// controller plus downstream logic (slave).
interface clock_reset_sequencer_if;
    import clk_seq_pkg::*;

    logic                locked_in;
    logic                clk_rst;
    logic                sys_rst;
    logic                ready;
    logic                fail;
    logic [RETRY_W-1:0]  retry_count;
    logic [LOSS_W-1:0]   loss_count;

    modport master (
        input  locked_in,
        output clk_rst, sys_rst, ready, fail, retry_count, loss_count
    );

    modport slave (
        output locked_in,
        input  clk_rst, sys_rst, ready, fail, retry_count, loss_count
    );

endinterface

// File: rtl/clock_reset_sequencer_sync.sv
// Two-flop synchronizer bringing the asynchronous lock status into clk_33.
module sync_2ff (
    input  logic clk_33,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture; both stages cleared by reset
    always_ff @(posedge clk_33) begin
        if (rst) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/clock_reset_sequencer.sv
// Power-up sequencer: pulses the PLL/DCM reset, waits for a stable lock, then
// releases the system reset. Optional lock-loss counter: CLK_SEQ_LOSS_COUNT_EN.
module clock_reset_sequencer
    import clk_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                      clk_33,
    input  logic                      rst,
    clock_reset_sequencer_if.master   seq
);

    localparam int PULSE_W = $clog2(RST_PULSE_CYCLES);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES);
    localparam int STAB_W  = $clog2(LOCK_STABLE_CYCLES);

    localparam logic [PULSE_W-1:0] PULSE_LAST  = PULSE_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST   = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    seq_state_e          state_r;
    logic [PULSE_W-1:0]  pulse_cnt_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic [STAB_W-1:0]   stab_cnt_r;
    logic [RETRY_W-1:0]  retry_cnt_r;
    logic [RETRY_W-1:0]  retry_next_s;
    logic                clk_rst_r;
    logic                sys_rst_r;
    logic                ready_r;
    logic                fail_r;
    logic                locked_s;

    sync_2ff u_lock_sync (
        .clk_33 (clk_33),
        .rst    (rst),
        .d      (seq.locked_in),
        .q      (locked_s)
    );

    // Retry count after the attempt that is timing out now
    always_comb begin
        retry_next_s = retry_cnt_r + 3'd1;
    end

    // Sequencer FSM; each counter is only non-zero in its own state and is
    // cleared on exit, so every state is entered with all counters at zero
    always_ff @(posedge clk_33) begin
        if (rst) begin
            state_r     <= ST_RESET_PULSE;
            pulse_cnt_r <= PULSE_W'(1'b0);
            tmo_cnt_r   <= TMO_W'(1'b0);
            stab_cnt_r  <= STAB_W'(1'b0);
            retry_cnt_r <= 3'd0;
            clk_rst_r   <= 1'b1;
            sys_rst_r   <= 1'b1;
            ready_r     <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_RESET_PULSE: begin
                    if (pulse_cnt_r == PULSE_LAST) begin
                        state_r     <= ST_WAIT_LOCK;
                        pulse_cnt_r <= PULSE_W'(1'b0);
                        clk_rst_r   <= 1'b0;
                    end else begin
                        pulse_cnt_r <= pulse_cnt_r + PULSE_W'(1'b1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock seen on the timeout cycle takes priority over the retry
                    if (locked_s) begin
                        state_r   <= ST_STABLE_WAIT;
                        tmo_cnt_r <= TMO_W'(1'b0);
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        tmo_cnt_r   <= TMO_W'(1'b0);
                        retry_cnt_r <= retry_next_s;
                        clk_rst_r   <= 1'b1;
                        if (retry_next_s == RETRY_LIMIT) begin
                            state_r <= ST_FAILED;
                            fail_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RESET_PULSE;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
                    end
                end
                ST_STABLE_WAIT: begin
                    if (!locked_s) begin
                        state_r    <= ST_WAIT_LOCK;
                        stab_cnt_r <= STAB_W'(1'b0);
                    end else if (stab_cnt_r == STAB_LAST) begin
                        state_r     <= ST_RUN;
                        stab_cnt_r  <= STAB_W'(1'b0);
                        retry_cnt_r <= 3'd0;
                        sys_rst_r   <= 1'b0;
                        ready_r     <= 1'b1;
                    end else begin
                        stab_cnt_r <= stab_cnt_r + STAB_W'(1'b1);
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_r   <= ST_RESET_PULSE;
                        clk_rst_r <= 1'b1;
                        sys_rst_r <= 1'b1;
                        ready_r   <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_FAILED: begin
                    state_r <= ST_FAILED;
                end
                default: begin
                    state_r     <= ST_RESET_PULSE;
                    pulse_cnt_r <= PULSE_W'(1'b0);
                    tmo_cnt_r   <= TMO_W'(1'b0);
                    stab_cnt_r  <= STAB_W'(1'b0);
                    clk_rst_r   <= 1'b1;
                    sys_rst_r   <= 1'b1;
                    ready_r     <= 1'b0;
                    fail_r      <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_SEQ_LOSS_COUNT_EN
    logic [LOSS_W-1:0] loss_cnt_r;

    // One event per RUN -> RESET_PULSE exit, saturating; cleared only by rst
    always_ff @(posedge clk_33) begin
        if (rst) begin
            loss_cnt_r <= 8'd0;
        end else if ((state_r == ST_RUN) && !locked_s) begin
            loss_cnt_r <= sat_inc_loss(loss_cnt_r);
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign seq.loss_count = loss_cnt_r;
`else
    assign seq.loss_count = {LOSS_W{1'b0}};
`endif

    assign seq.clk_rst     = clk_rst_r;
    assign seq.sys_rst     = sys_rst_r;
    assign seq.ready       = ready_r;
    assign seq.fail        = fail_r;
    assign seq.retry_count = retry_cnt_r;

endmodule

// File: doc/clock_reset_sequencer.md
CLOCK_RESET_SEQUENCER -- requirements
Module: clock_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: cycles clk_rst is held high per attempt (>=2).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles allowed in WAIT_LOCK before a retry.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: cycles locked must stay high before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 7: failed attempts before FAILED (1..7).
REQ-005 SHALL have port clk_33, input, 1: single free-running clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port locked_in, input, 1: asynchronous lock status from the clock controller.
REQ-008 SHALL have port clk_rst, output, 1: reset driven to the clock controller's PLL/DCM chain.
REQ-009 SHALL have port sys_rst, output, 1: active-high reset request to the downstream logic.
REQ-010 SHALL have port ready, output, 1: high only in RUN.
REQ-011 SHALL have port fail, output, 1: high only in FAILED.
REQ-012 SHALL have port retry_count, output, 3: failed attempts since the last entry to RUN or reset.
REQ-013 SHALL have port loss_count, output, 8: lock-loss events while in RUN (see Configuration).

Function
REQ-014 SHALL synchronize locked_in through two flip-flops into locked_s, giving 2 cycles of latency; no other logic uses locked_in directly.
REQ-015 SHALL implement the states RESET_PULSE, WAIT_LOCK, STABLE_WAIT, RUN and FAILED, with all outputs registered.
REQ-016 In RESET_PULSE: clk_rst=1 and sys_rst=1; after exactly RST_PULSE_CYCLES cycles -> WAIT_LOCK.
REQ-017 In WAIT_LOCK: clk_rst=0 and sys_rst=1; timer counts up from 0.
REQ-018 WAIT_LOCK, locked_s=1: go to STABLE_WAIT and clear the stable counter.
REQ-019 WAIT_LOCK timeout: when the timer reaches LOCK_TIMEOUT_CYCLES-1 with locked_s=0, increment retry_count; if the new value equals MAX_RETRIES, go to FAILED, else go to RESET_PULSE.
REQ-020 If locked_s rises on the timeout cycle, lock wins: go to STABLE_WAIT and do not increment retry_count.
REQ-021 In STABLE_WAIT: sys_rst=1; if locked_s=0, go to WAIT_LOCK with the timer restarted at 0.
REQ-022 STABLE_WAIT: after LOCK_STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN.
REQ-023 In RUN: sys_rst=0, ready=1 and retry_count cleared to 0 on entry; on locked_s=0, go to RESET_PULSE, with sys_rst=1 and ready=0 from the next cycle.
REQ-024 FAILED is sticky until rst: clk_rst=1, sys_rst=1, fail=1, retry_count holds its value.
REQ-025 Counters SHALL be sized with $clog2 of their parameter, never wrap, and reset to 0 on every state entry.

Reset
REQ-026 rst=1 SHALL, in the next cycle, force state=RESET_PULSE with all counters=0, clk_rst=1, sys_rst=1, ready=0, fail=0, retry_count=0, loss_count=0, and both synchronizer flops=0.
REQ-027 rst asserted in any state, including FAILED or mid-pulse, SHALL restart the full sequence with a full-length RESET_PULSE.

Configuration
REQ-028 With CLK_SEQ_LOSS_COUNT_EN defined: loss_count SHALL increment, saturating at 255, on each RUN->RESET_PULSE transition, and clear only on rst.
REQ-029 With CLK_SEQ_LOSS_COUNT_EN undefined: loss_count SHALL be tied to 0 and no counter logic is generated.

Structure
REQ-030 Package clk_seq_pkg SHALL hold the state enum and the retry/loss counter width constants.
REQ-031 The two-flop synchronizer SHALL be a sub-module, sync_2ff.

Verification (RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-032 Release rst, raise locked_in 10 cycles later -> clk_rst high for exactly 4 cycles; ready and sys_rst=0 exactly 2+8 cycles after locked_s condition met.
REQ-033 Hold locked_in=0 -> two RESET_PULSE/WAIT_LOCK rounds, then fail=1, retry_count=2, clk_rst=1 held for 1000 cycles.
REQ-034 In STABLE_WAIT, drop locked_in for 1 cycle at stable count 5 -> return to WAIT_LOCK; RUN reached only after a fresh 8-cycle stable window.
REQ-035 In RUN, drop locked_in -> sys_rst=1 within 3 cycles and a new 4-cycle clk_rst pulse; with CLK_SEQ_LOSS_COUNT_EN, loss_count=1; after 300 losses, loss_count=255.
REQ-036 Assert rst for 1 cycle while in FAILED and mid-RESET_PULSE -> outputs match REQ-026, and a full 4-cycle pulse follows.
